// File: rtl/ceas_timp.sv
// ceas_timp: timekeeping stage. Keeps the running time HH:MM:SS and the alarm
// HH:MM, applies button edits in the setting modes and drives the ring flag.
module ceas_timp #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned RING_SECONDS  = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       semnal_setare,
  input  logic       semnal_setare_a,
  input  logic       semnal_stop,
  input  logic       semnal_b1,
  input  logic       semnal_b2,
  output logic [4:0] ora,
  output logic [5:0] minut,
  output logic [5:0] secunda,
  output logic [4:0] alarm_ora,
  output logic [5:0] alarm_minut,
  output logic       camp,
  output logic [1:0] mod,
  output logic       alarma,
  output logic       tick_sec
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [RW-1:0] RING_MAX  = RW'(RING_SECONDS - 1);

  localparam logic [1:0] M_RUN       = 2'd0;
  localparam logic [1:0] M_SET_TIME  = 2'd1;
  localparam logic [1:0] M_SET_ALARM = 2'd2;

  logic [PW-1:0] presc, presc_nx;
  logic [RW-1:0] ring_cnt, ring_cnt_nx;
  logic          b1_q, b2_q;

  logic [4:0] ora_nx, alarm_ora_nx;
  logic [5:0] minut_nx, secunda_nx, alarm_minut_nx;
  logic       camp_nx, alarma_nx, tick_nx;
  logic [1:0] mod_nx;
  logic       e1, e2, running, tick, trigger;
  logic       enter_edit, enter_set_time, leave_set_time;

  // Next-state computation: mode, prescaler, time advance, edits and alarm.
  always_comb begin
    mod_nx = semnal_setare   ? M_SET_TIME  :
             semnal_setare_a ? M_SET_ALARM : M_RUN;
    e1 = semnal_b1 & ~b1_q;
    e2 = semnal_b2 & ~b2_q;
    running        = (mod != M_SET_TIME);
    tick           = running && (presc == PRESC_MAX);
    enter_edit     = (mod_nx != mod) && (mod_nx != M_RUN);
    enter_set_time = (mod_nx == M_SET_TIME) && (mod != M_SET_TIME);
    leave_set_time = (mod == M_SET_TIME) && (mod_nx == M_RUN);

    ora_nx         = ora;
    minut_nx       = minut;
    secunda_nx     = secunda;
    alarm_ora_nx   = alarm_ora;
    alarm_minut_nx = alarm_minut;
    camp_nx        = camp;
    alarma_nx      = alarma;
    ring_cnt_nx    = ring_cnt;
    tick_nx        = tick;

    if (!running || tick) presc_nx = '0;
    else                  presc_nx = presc + 1'b1;

    // Seconds carry into minutes and minutes into hours within one cycle.
    if (tick) begin
      if (secunda == 6'd59) begin
        secunda_nx = '0;
        if (minut == 6'd59) begin
          minut_nx = '0;
          ora_nx   = (ora == 5'd23) ? '0 : ora + 1'b1;
        end else begin
          minut_nx = minut + 1'b1;
        end
      end else begin
        secunda_nx = secunda + 1'b1;
      end
    end

    if (mod == M_SET_TIME && e1) begin
      if (!camp) ora_nx   = (ora == 5'd23)   ? '0 : ora + 1'b1;
      else       minut_nx = (minut == 6'd59) ? '0 : minut + 1'b1;
    end

    if (mod == M_SET_ALARM && e1) begin
      if (!camp) alarm_ora_nx   = (alarm_ora == 5'd23)   ? '0 : alarm_ora + 1'b1;
      else       alarm_minut_nx = (alarm_minut == 6'd59) ? '0 : alarm_minut + 1'b1;
    end

    // A b1 edge in the same cycle wins: the toggle is dropped so the
    // increment lands on the field that was selected before.
    if (mod != M_RUN && e2 && !e1) camp_nx = ~camp;
    if (enter_edit) camp_nx = 1'b0;

    if (leave_set_time) begin
      secunda_nx = '0;
      presc_nx   = '0;
    end

    trigger = tick && (mod == M_RUN) && (secunda_nx == 6'd0) &&
              (ora_nx == alarm_ora) && (minut_nx == alarm_minut);

    if (semnal_stop || enter_set_time) begin
      alarma_nx   = 1'b0;
      ring_cnt_nx = '0;
    end else if (trigger) begin
      alarma_nx   = 1'b1;
      ring_cnt_nx = '0;
    end else if (alarma && tick) begin
      if (ring_cnt == RING_MAX) begin
        alarma_nx   = 1'b0;
        ring_cnt_nx = '0;
      end else begin
        ring_cnt_nx = ring_cnt + 1'b1;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc       <= '0;
      ring_cnt    <= '0;
      b1_q        <= 1'b0;
      b2_q        <= 1'b0;
      ora         <= '0;
      minut       <= '0;
      secunda     <= '0;
      alarm_ora   <= 5'd7;
      alarm_minut <= '0;
      camp        <= 1'b0;
      mod         <= M_RUN;
      alarma      <= 1'b0;
      tick_sec    <= 1'b0;
    end else begin
      presc       <= presc_nx;
      ring_cnt    <= ring_cnt_nx;
      b1_q        <= semnal_b1;
      b2_q        <= semnal_b2;
      ora         <= ora_nx;
      minut       <= minut_nx;
      secunda     <= secunda_nx;
      alarm_ora   <= alarm_ora_nx;
      alarm_minut <= alarm_minut_nx;
      camp        <= camp_nx;
      mod         <= mod_nx;
      alarma      <= alarma_nx;
      tick_sec    <= tick_nx;
    end
  end

endmodule
